fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
Shares the single framebuffer write port (dst_addr/dst_data/dst_wr) between NUM_REQ render clients, such as the HUD number renderer, map tile blitter and sprite drawer.
- Each client uses a valid/ready handshake.
- Grants are round-robin with bounded bursts.
- Writes are registered toward the framebuffer, and out-of-range addresses are dropped.
- Sits between the render engines and the VRAM write side.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 19, framebuffer word address width
DATA_W, 16, pixel width (RGB565)
MAX_BURST, 16, max consecutive accepted writes per grant before forced rotation (>=1)
FB_WORDS, 307200, valid address range 0..FB_WORDS-1 (640x480)

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester accept, combinational from state
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed pixel data, same packing
dst_addr  out  ADDR_W  framebuffer write address, registered
dst_data  out  DATA_W  framebuffer write data, registered
dst_wr  out  1  one-cycle write strobe per performed write
grant_id  out  clog2(NUM_REQ)  current/last granted requester
busy  out  1  high in GRANT state
err_oob  out  1  sticky: an out-of-range address was accepted and dropped

Behaviour:
- Single clock. Reset is synchronous, active-low, sampled on posedge clk.
- Reset values:
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - burst_cnt=0.
  - dst_addr=0, dst_data=0, dst_wr=0, grant_id=0, busy=0, err_oob=0.
  - req_ready=0.
- States: IDLE, GRANT.
- IDLE:
  - req_ready all 0.
  - If any req_valid: pick the first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Set grant_id to that requester, burst_cnt=0, go to GRANT.
  - Arbitration latency is 1 cycle: req_ready rises the cycle after valid is first seen.
- GRANT:
  - req_ready[grant_id]=1; all other ready bits 0.
  - Transfer occurs when req_valid[g] && req_ready[g].
  - On transfer: burst_cnt increments. Next cycle, dst_wr=1 with dst_addr/dst_data holding the transferred values, provided addr<FB_WORDS.
  - Otherwise dst_wr=0 and err_oob sets. The requester still sees the transfer as accepted.
- Release condition, evaluated each GRANT cycle:
  - req_valid[g]==0, or
  - a transfer occurs with burst_cnt==MAX_BURST-1.
- On release:
  - last_grant=g.
  - If any req_valid is set in the same cycle, pick next via round-robin from g+1 (g itself is last candidate) and stay in GRANT with burst_cnt=0. There is no bubble.
  - Else go to IDLE.
- The rotation pick on a burst-limit release sees the current-cycle req_valid[g].
  - g is only re-granted if no other requester is valid.
- Throughput: one write per cycle while granted. Full rotation between requesters costs no idle cycle.
- dst_addr/dst_data hold their last values when dst_wr=0.
- grant_id holds its last value in IDLE.
- Requesters may drop valid without a transfer. This is treated as end of burst.
- Data/addr are only sampled from the granted requester on a transfer. Other inputs are ignored.
- Reset asserted mid-burst:
  - Next edge returns to reset values.
  - Any write registered in that cycle is discarded: dst_wr=0.
- err_oob clears only on reset.

Optional Feature:
FB_ARB_FIXED_PRIO_EN:
- When defined, every arbitration point (IDLE pick and release pick) selects the lowest-index valid requester, ignoring last_grant.
- MAX_BURST still forces release, but re-pick may return the same requester.
- Requester 0 has strict priority; this is for HUD-over-map overlay.
- When undefined, round-robin as above.

Test Plan:
- Reset then req_valid=4'b0001, addr=100, data=16'hF800 held for 3 cycles -> req_ready[0] rises cycle 1; dst_wr pulses at cycles 2,3,4 with addr 100, data F800.
- req_valid=4'b1111 constant, MAX_BURST=16 -> grants 0,1,2,3,0... each exactly 16 transfers; no cycle with dst_wr=0 between bursts; grant_id sequence verified.
- Requester 2 valid for 5 writes then drops, requester 3 valid -> grant moves to 3 the cycle after req2 drop; exactly 5 writes from 2.
- Requester 1 writes addr=307200 then addr=307199 -> first accepted, no dst_wr, err_oob=1; second produces dst_wr with addr 307199; err_oob stays 1.
- Assert rstn=0 mid-burst of requester 1 -> next cycle busy=0, req_ready=0, dst_wr=0, err_oob=0; after release, requester 0 is granted first.
- FB_ARB_FIXED_PRIO_EN defined, req_valid=4'b0011 constant -> requester 0 granted every rotation, requester 1 never granted until req 0 drops.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
//
// Shares the single framebuffer write port between NUM_REQ render clients
// (HUD number renderer, map tile blitter, sprite drawer, ...). Each client
// presents a valid/ready handshake. Grants rotate round-robin; a grant is
// released when its owner drops valid or after MAX_BURST accepted writes, and
// the next owner is picked in the same cycle so rotation costs no bubble.
// Accepted writes are registered toward VRAM. A write whose address lies
// outside 0..FB_WORDS-1 is still accepted but dropped, and flags err_oob.
//
// Optional feature macro: FB_ARB_FIXED_PRIO_EN
//   When defined, every arbitration point picks the lowest-index valid
//   requester (requester 0 has strict priority, for HUD-over-map overlay).
//   MAX_BURST still forces a release, but the re-pick may return the same
//   requester. When undefined, arbitration is round-robin.
//
// Ports:
//   clk        in   system clock
//   rstn       in   synchronous active-low reset
//   req_valid  in   [NUM_REQ]          per-requester write request
//   req_ready  out  [NUM_REQ]          per-requester accept (decoded from state)
//   req_addr   in   [NUM_REQ*ADDR_W]   packed addresses, req i at [i*ADDR_W +: ADDR_W]
//   req_data   in   [NUM_REQ*DATA_W]   packed pixel data, same packing
//   dst_addr   out  [ADDR_W]           framebuffer write address (registered)
//   dst_data   out  [DATA_W]           framebuffer write data (registered)
//   dst_wr     out                     one-cycle write strobe per performed write
//   grant_id   out  [clog2(NUM_REQ)]   current/last granted requester
//   busy       out                     high while a grant is held
//   err_oob    out                     sticky out-of-range drop flag
// -----------------------------------------------------------------------------
module fb_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16,
  parameter int FB_WORDS  = 307200
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [ADDR_W-1:0]           dst_addr,
  output logic [DATA_W-1:0]           dst_data,
  output logic                        dst_wr,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        err_oob
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0]     BURST_LAST = BW'(MAX_BURST - 1);
  // One extra bit so the limit itself is representable next to the address.
  localparam logic [ADDR_W:0]   FB_LIMIT   = (ADDR_W + 1)'(FB_WORDS);
  localparam logic [GW-1:0]     GRANT_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e              state_r, state_s;
  logic [GW-1:0]       grant_r, grant_s;
  logic [GW-1:0]       last_grant_r, last_grant_s;
  logic [BW-1:0]       burst_cnt_r, burst_cnt_s;
  logic                release_s;
  logic                xfer_s;
  logic                in_range_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;

  logic [ADDR_W-1:0]   dst_addr_r;
  logic [DATA_W-1:0]   dst_data_r;
  logic                dst_wr_r;
  logic                err_oob_r;

  // Arbitration pick. Round-robin scans after+1, after+2, ... so that 'after'
  // itself is the last candidate; fixed priority takes the lowest index.
  function automatic logic [GW-1:0] pick_next(input logic [NUM_REQ-1:0] valid,
                                              input logic [GW-1:0]      after);
    logic [GW-1:0] pick;
`ifdef FB_ARB_FIXED_PRIO_EN
    pick = after;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        pick = GW'(i);
      end else begin
        pick = pick;
      end
    end
`else
    logic found;
    int   idx;
    pick  = after;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(after) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
`endif
    return pick;
  endfunction

  // Payload of the current owner and whether it lands inside the framebuffer.
  always_comb begin
    sel_addr_s = req_addr[grant_r*ADDR_W +: ADDR_W];
    sel_data_s = req_data[grant_r*DATA_W +: DATA_W];
    in_range_s = ({1'b0, sel_addr_s} < FB_LIMIT);
    xfer_s     = (state_r == ST_GRANT) && req_valid[grant_r];
  end

  // Next-state logic: grant selection, burst counting and release/re-pick.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    burst_cnt_s  = burst_cnt_r;
    release_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          state_s     = ST_GRANT;
          grant_s     = pick_next(req_valid, last_grant_r);
          burst_cnt_s = {BW{1'b0}};
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Owner dropping valid ends the burst; so does its last allowed write.
        if (!req_valid[grant_r]) begin
          release_s = 1'b1;
        end else if (burst_cnt_r == BURST_LAST) begin
          release_s = 1'b1;
        end else begin
          burst_cnt_s = burst_cnt_r + BW'(1);
        end
        if (release_s) begin
          last_grant_s = grant_r;
          burst_cnt_s  = {BW{1'b0}};
          // Re-pick in the same cycle so the port never idles between owners.
          if (|req_valid) begin
            state_s = ST_GRANT;
            grant_s = pick_next(req_valid, grant_r);
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_GRANT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      grant_r      <= {GW{1'b0}};
      last_grant_r <= GRANT_INIT;
      burst_cnt_r  <= {BW{1'b0}};
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      burst_cnt_r  <= burst_cnt_s;
    end
  end

  // Registered write port; out-of-range writes are swallowed and flagged.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dst_addr_r <= {ADDR_W{1'b0}};
      dst_data_r <= {DATA_W{1'b0}};
      dst_wr_r   <= 1'b0;
      err_oob_r  <= 1'b0;
    end else begin
      dst_wr_r <= xfer_s && in_range_s;
      if (xfer_s && in_range_s) begin
        dst_addr_r <= sel_addr_s;
        dst_data_r <= sel_data_s;
      end else begin
        dst_addr_r <= dst_addr_r;
        dst_data_r <= dst_data_r;
      end
      if (xfer_s && !in_range_s) begin
        err_oob_r <= 1'b1;
      end else begin
        err_oob_r <= err_oob_r;
      end
    end
  end

  // Ready is a pure decode of the held grant, so it never depends on valid.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (state_r == ST_GRANT) begin
      req_ready[grant_r] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  assign dst_addr = dst_addr_r;
  assign dst_data = dst_data_r;
  assign dst_wr   = dst_wr_r;
  assign grant_id = grant_r;
  assign busy     = (state_r == ST_GRANT);
  assign err_oob  = err_oob_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_write_arbiter
//
// Self-checking bench for fb_write_arbiter. A transaction-level model (owner
// index, transfers done in the current grant, last owner) predicts every
// output after each clock edge; one compare process checks the DUT against it
// on every falling edge. Directed scenarios add literal expectations, then a
// long randomized phase exercises valid churn, out-of-range addresses and
// resets. Define FB_ARB_FIXED_PRIO_EN for both bench and RTL to cover the
// fixed-priority variant.
// -----------------------------------------------------------------------------
module tb_fb_write_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 19;
  localparam int DW  = 16;
  localparam int MB  = 16;
  localparam int FBW = 307200;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR*AW-1:0]     req_addr;
  logic [NR*DW-1:0]     req_data;
  logic [AW-1:0]        dst_addr;
  logic [DW-1:0]        dst_data;
  logic                 dst_wr;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 err_oob;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: owner (-1 = nobody), transfers done in this grant, last owner.
  int            m_owner;
  int            m_cnt;
  int            m_last;
  logic          exp_wr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          exp_err;
  int            exp_gid;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .NUM_REQ  (NR),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_BURST(MB),
    .FB_WORDS (FBW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_data (req_data),
    .dst_addr (dst_addr),
    .dst_data (dst_data),
    .dst_wr   (dst_wr),
    .grant_id (grant_id),
    .busy     (busy),
    .err_oob  (err_oob)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // Who wins an arbitration point given the valid set and the previous owner.
  function automatic int choose(input logic [NR-1:0] v, input int last);
`ifdef FB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
`endif
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    logic [NR-1:0] r;
    r = '0;
    if (m_owner >= 0) r[m_owner] = 1'b1;
    return r;
  endfunction

  // Reference model: advance one clock using the inputs seen at this edge.
  always @(posedge clk) begin
    logic [AW-1:0] a;
    bit rel;
    if (!rstn) begin
      m_owner = -1; m_cnt = 0; m_last = NR - 1;
      exp_wr = 1'b0; exp_addr = '0; exp_data = '0; exp_err = 1'b0; exp_gid = 0;
    end else begin
      exp_wr = 1'b0;
      rel    = 1'b0;
      if (m_owner < 0) begin
        if (req_valid != '0) begin
          m_owner = choose(req_valid, m_last);
          m_cnt   = 0;
          exp_gid = m_owner;
        end
      end else if (req_valid[m_owner]) begin
        a = req_addr[m_owner*AW +: AW];
        if (a < FBW) begin
          exp_wr   = 1'b1;
          exp_addr = a;
          exp_data = req_data[m_owner*DW +: DW];
        end else begin
          exp_err = 1'b1;
        end
        m_cnt++;
        if (m_cnt == MB) rel = 1'b1;
      end else begin
        rel = 1'b1;
      end
      if (rel) begin
        m_last  = m_owner;
        m_cnt   = 0;
        m_owner = (req_valid != '0) ? choose(req_valid, m_last) : -1;
        if (m_owner >= 0) exp_gid = m_owner;
      end
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",    req_ready, exp_ready());
      chk("busy",     busy,      (m_owner >= 0));
      chk("grant_id", grant_id,  exp_gid);
      chk("dst_wr",   dst_wr,    exp_wr);
      chk("dst_addr", dst_addr,  exp_addr);
      chk("dst_data", dst_data,  exp_data);
      chk("err_oob",  err_oob,   exp_err);
    end
  end

  initial begin
    int writes;
    rstn      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_busy",  busy,      1'b0);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_wr",    dst_wr,    1'b0);
    chk("rst_gid",   grant_id,  2'd0);
    chk("rst_err",   err_oob,   1'b0);
    chk("rst_addr",  dst_addr,  19'd0);
    chk("rst_model_last", m_last, NR - 1);
    rstn = 1'b1;

    // Single requester: ready one cycle after valid, then a write per cycle.
    set_req(0, 19'd100, 16'hF800);
    req_valid = 4'b0001;
    tick();
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_wr0",   dst_wr,    1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_wr",   dst_wr,   1'b1);
      chk("t1_addr", dst_addr, 19'd100);
      chk("t1_data", dst_data, 16'hF800);
    end
    req_valid = 4'b0000;
    tick();
    chk("t1_wr_end", dst_wr, 1'b0);
    chk("t1_idle",   busy,   1'b0);

    // All valid: 16-write bursts rotating 0,1,2,3,0 with no gap.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(i * 1000), DW'(16'hA000 + i));
    req_valid = 4'b1111;
    tick();
    for (int k = 0; k <= 64; k++) begin
`ifdef FB_ARB_FIXED_PRIO_EN
      chk("t2_gid", grant_id, 2'd0);
`else
      chk("t2_gid",       grant_id, (k / 16) % 4);
      chk("t2_model_gid", m_owner,  (k / 16) % 4);
      if (k > 0) chk("t2_data", dst_data, 16'hA000 + ((k - 1) / 16) % 4);
`endif
      if (k > 0) chk("t2_wr", dst_wr, 1'b1);
      tick();
    end
    req_valid = 4'b0000;
    tick();

    // Requester 2 writes five times, drops; requester 3 takes over at once.
    do_reset();
    set_req(2, 19'd2222, 16'h0F0F);
    set_req(3, 19'd3333, 16'h1234);
    req_valid = 4'b0100;
    tick();
    chk("t3_gid2", grant_id, 2'd2);
    writes = 0;
    repeat (5) begin
      tick();
      writes += int'(dst_wr);
    end
    req_valid = 4'b1000;
    tick();
    chk("t3_writes", writes,    5);
    chk("t3_gid3",   grant_id,  2'd3);
    chk("t3_ready",  req_ready, 4'b1000);
    chk("t3_nowr",   dst_wr,    1'b0);
    tick();
    chk("t3_wr3",   dst_wr,   1'b1);
    chk("t3_addr3", dst_addr, 19'd3333);
    req_valid = 4'b0000;
    tick();

    // Out-of-range write dropped and flagged; last legal word written.
    do_reset();
    set_req(1, 19'd307200, 16'h07E0);
    req_valid = 4'b0010;
    tick();
    chk("t4_ready", req_ready, 4'b0010);
    tick();
    chk("t4_oob_wr",  dst_wr,  1'b0);
    chk("t4_oob_err", err_oob, 1'b1);
    set_req(1, 19'd307199, 16'h001F);
    tick();
    chk("t4_wr",   dst_wr,   1'b1);
    chk("t4_addr", dst_addr, 19'd307199);
    chk("t4_data", dst_data, 16'h001F);
    chk("t4_err",  err_oob,  1'b1);

    // Reset in the middle of requester 1's burst.
    tick();
    tick();
    rstn = 1'b0;
    tick();
    chk("t5_busy",  busy,      1'b0);
    chk("t5_ready", req_ready, 4'b0000);
    chk("t5_wr",    dst_wr,    1'b0);
    chk("t5_err",   err_oob,   1'b0);
    rstn = 1'b1;
    req_valid = 4'b0011;
    tick();
    chk("t5_gid",    grant_id,  2'd0);
    chk("t5_ready0", req_ready, 4'b0001);
    req_valid = 4'b0000;
    tick();

`ifdef FB_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 keeps winning across burst limits.
    do_reset();
    req_valid = 4'b0011;
    tick();
    repeat (40) begin
      chk("t6_gid0", grant_id, 2'd0);
      tick();
    end
    req_valid = 4'b0010;
    tick();
    chk("t6_gid1", grant_id, 2'd1);
    req_valid = 4'b0000;
    tick();
`endif

    // Randomized phase: valid churn, boundary addresses, occasional reset.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NR; i++) begin
        int r;
        if ($urandom_range(0, 4) == 0) req_valid[i] = ~req_valid[i];
        r = $urandom_range(0, 15);
        if (r == 0)      set_req(i, AW'(FBW + $urandom_range(0, 2000)), DW'($urandom));
        else if (r == 1) set_req(i, AW'(FBW - 1), DW'($urandom));
        else             set_req(i, AW'($urandom_range(0, FBW - 1)), DW'($urandom));
      end
      rstn = ($urandom_range(0, 599) != 0);
      tick();
    end
    rstn      = 1'b1;
    req_valid = '0;
    tick();
    tick();
    chk_en = 1'b0;
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
